// File: rtl/imem_loader.sv
// Boot loader: streams header/words/checksum into instruction memory; write strobe one cycle after each data transfer.
// Backpressure: in_ready is decoded from state only and drops in S_DONE/S_ERR until reload or reset.
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [31:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state;
  logic [31:0] count;
  logic [31:0] csum;
  logic [31:0] ptr;
  logic        xfer;

  assign in_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_HDR;
      count        <= '0;
      csum         <= '0;
      ptr          <= BASE_ADDR;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR: begin
          if (xfer) begin
            count        <= in_data;
            csum         <= in_data;
            words_loaded <= '0;
            ptr          <= BASE_ADDR;
            if (in_data > DEPTH_W) begin
              state      <= S_ERR;
              load_error <= 1'b1;
            end else if (in_data == 32'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            imem_we      <= 1'b1;
            imem_addr    <= ptr;
            imem_wdata   <= in_data;
            ptr          <= ptr + 32'd4;
            csum         <= csum ^ in_data;
            words_loaded <= words_loaded + 32'd1;
            if (words_loaded + 32'd1 == count) state <= S_CHK;
          end
        end
        S_CHK: begin
          // The checksum word is compared only; it never reaches memory.
          if (xfer) begin
            if (in_data == csum) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state      <= S_ERR;
              load_error <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (reload) begin
            state     <= S_HDR;
            load_done <= 1'b0;
            cpu_reset <= 1'b1;
          end
        end
        S_ERR: begin
          if (reload) begin
            state      <= S_HDR;
            load_error <= 1'b0;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed stream tests; expected writes go to a scoreboard drained by a negedge monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [31:0] words_loaded;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_ptr;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every write strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", imem_addr, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e[63:32]);
        chk("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [31:0] d, input int gap);
    chk("in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic hdr(input logic [31:0] n, input int gap);
    exp_ptr = 32'h0;
    send(n, gap);
  endtask

  task automatic dat(input logic [31:0] d, input int gap);
    exp_q.push_back({exp_ptr, d});
    exp_ptr += 32'd4;
    send(d, gap);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic done, input logic err,
                            input logic cr, input logic [31:0] wl);
    chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    chk({tag, "_load_error"}, {31'd0, load_error}, {31'd0, err});
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
    chk({tag, "_words_loaded"}, words_loaded, wl);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'h0);
    chk_status(tag, 1'b0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic prog3(input int gap);
    hdr(32'd3, gap);
    dat(32'h2008_0005, gap);
    dat(32'h2009_0007, gap);
    dat(32'h0109_5020, gap);
    send(32'h0108_5021, 0);  // 3 ^ the three words
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Continuous stream
    prog3(0);
    chk_status("cont", 1'b1, 1'b0, 1'b0, 32'd3);
    chk("cont_in_ready_done", {31'd0, in_ready}, 32'd0);

    // Reload with in_valid in S_DONE: word must not be consumed
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    pulse_reload();
    in_valid = 1'b0;
    chk("reload_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("reload_load_done", {31'd0, load_done}, 32'd0);

    // Stalled stream: two idle cycles after each word
    prog3(2);
    repeat (2) begin @(posedge clk); #1; end
    chk_status("stall", 1'b1, 1'b0, 1'b0, 32'd3);
    pulse_reload();

    // Bad checksum, then recovery
    hdr(32'd2, 0);
    dat(32'hA, 0);
    dat(32'hB, 0);
    send(32'h0, 0);
    chk_status("badsum", 1'b0, 1'b1, 1'b1, 32'd2);
    chk("badsum_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_reload();
    chk("badsum_reload_err", {31'd0, load_error}, 32'd0);
    hdr(32'd2, 0);
    dat(32'hA, 0);
    dat(32'hB, 0);
    send(32'h3, 0);
    chk_status("recover", 1'b1, 1'b0, 1'b0, 32'd2);
    pulse_reload();

    // Oversized header
    send(32'd257, 0);
    chk("big_load_error", {31'd0, load_error}, 32'd1);
    chk("big_in_ready", {31'd0, in_ready}, 32'd0);
    chk("big_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    pulse_reload();

    // Empty image
    hdr(32'd0, 0);
    send(32'h0, 0);
    chk_status("empty", 1'b1, 1'b0, 1'b0, 32'd0);
    pulse_reload();
    hdr(32'd0, 0);
    send(32'h1, 0);
    chk_status("empty_bad", 1'b0, 1'b1, 1'b1, 32'd0);
    pulse_reload();

    // Reset mid-stream, then a fresh full load from BASE_ADDR
    hdr(32'd4, 0);
    dat(32'h11, 0);
    dat(32'h22, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midreset");
    reset = 1'b0;
    hdr(32'd4, 0);
    dat(32'h11, 0);
    dat(32'h22, 0);
    dat(32'h44, 0);
    dat(32'h88, 0);
    send(32'hFB, 0);
    chk_status("fresh", 1'b1, 1'b0, 1'b0, 32'd4);

    repeat (3) begin @(posedge clk); #1; end
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
